// File: rtl/maj_bist_pkg.sv
// Shared types and constants for the majority-gate BIST checker.
// Holds the FSM encoding, LFSR taps and the sizing helpers used by the top.
package maj_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int unsigned NUM_DIRECTED = 4;

    function automatic int thr(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int nch(input int n, input int chunk);
        return (n + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/maj_lfsr_chunk.sv
// 32-bit Galois LFSR unrolled CHUNK steps per enabled cycle.
// o_chunk[i] is the bit shifted out on step i, taken from the current state.
module maj_lfsr_chunk
    import maj_bist_pkg::*;
#(
    parameter int          CHUNK = 16,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    output logic [CHUNK-1:0] o_chunk
);

    logic [31:0]      r_state;
    logic [31:0]      w_state_nxt;
    logic [CHUNK-1:0] w_chunk;

    always_comb begin
        w_state_nxt = r_state;
        w_chunk     = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk[i]  = w_state_nxt[0];
            w_state_nxt = (w_state_nxt >> 1) ^ (w_state_nxt[0] ? LFSR_TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    assign o_chunk = w_chunk;

endmodule

// File: rtl/maj_bist_checker.sv
// Stimulus generator and response checker for an N-input majority gate.
// Optional MAJ_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module maj_bist_checker
    import maj_bist_pkg::*;
#(
    parameter int          N         = 255,
    parameter int          CHUNK     = 16,
    parameter int          NUM_VEC   = 1024,
    parameter int          SETTLE    = 2,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2025
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] dut_x,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [31:0]  vec_count,
    output logic [N-1:0] fail_vec,
    output state_t       dbg_state
);

    localparam int          THR      = thr(N);
    localparam int          NCH      = nch(N, CHUNK);
    localparam int          SW       = NCH * CHUNK;
    localparam int          AW       = $clog2(N + 1);
    localparam int          PCW      = $clog2(CHUNK + 1);
    localparam int          CIW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          STW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CIW-1:0]   r_chunk_idx;
    logic [STW-1:0]   r_settle_cnt;
    logic [SW-1:0]    r_shadow;
    logic [SW-1:0]    w_shadow_nxt;
    logic [AW-1:0]    r_acc;
    logic [N-1:0]     r_dut_x;
    logic [15:0]      r_err;
    logic [31:0]      r_vec;
    logic [N-1:0]     r_fail_vec;
    logic             r_first_fail;
    logic [CHUNK-1:0] w_lfsr_chunk;
    logic [CHUNK-1:0] w_chunk;
    logic [PCW-1:0]   w_pc;
    logic             w_directed;
    int               w_lim;
    logic             w_start_ok;
    logic             w_fill_last;
    logic             w_settle_last;
    logic             w_exp;
    logic             w_mis;
    logic             w_stop;

    assign w_directed    = (r_vec < NUM_DIRECTED);
    assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fill_last   = (r_chunk_idx == CIW'(NCH - 1));
    assign w_settle_last = (r_settle_cnt == STW'(SETTLE - 1));
    assign w_exp         = (r_acc >= AW'(THR));
    // Case inequality so an X/Z response is treated as a mismatch.
    assign w_mis         = (dut_y !== w_exp);

    maj_lfsr_chunk #(
        .CHUNK (CHUNK),
        .SEED  (SEED_EFF)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_start_ok),
        .i_en    ((r_state == ST_FILL) && !w_directed),
        .o_chunk (w_lfsr_chunk)
    );

    // Directed vectors are "the lowest w_lim bits set".
    always_comb begin
        case (r_vec[1:0])
            2'd0:    w_lim = 0;
            2'd1:    w_lim = N;
            2'd2:    w_lim = THR - 1;
            default: w_lim = THR;
        endcase
    end

    always_comb begin
        int j;
        w_chunk = '0;
        w_pc    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            j          = int'(r_chunk_idx) * CHUNK + i;
            w_chunk[i] = (j < N) && (w_directed ? (j < w_lim) : w_lfsr_chunk[i]);
            w_pc       = w_pc + PCW'(w_chunk[i]);
        end
        w_shadow_nxt = r_shadow;
        w_shadow_nxt[int'(r_chunk_idx) * CHUNK +: CHUNK] = w_chunk;
    end

    always_comb begin
        w_stop = (r_vec + 32'd1 == 32'(NUM_VEC));
`ifdef MAJ_BIST_STOP_ON_FAIL_EN
        w_stop = w_stop || w_mis;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_nxt = ST_FILL;
            ST_FILL:          if (w_fill_last) w_state_nxt = ST_SETTLE;
            ST_SETTLE:        if (w_settle_last) w_state_nxt = ST_CHECK;
            ST_CHECK:         w_state_nxt = w_stop ? ST_DONE : ST_FILL;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chunk_idx  <= '0;
            r_settle_cnt <= '0;
            r_shadow     <= '0;
            r_acc        <= '0;
            r_dut_x      <= '0;
            r_err        <= '0;
            r_vec        <= '0;
            r_fail_vec   <= '0;
            r_first_fail <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_chunk_idx  <= '0;
                        r_acc        <= '0;
                        r_err        <= '0;
                        r_vec        <= '0;
                        r_fail_vec   <= '0;
                        r_first_fail <= 1'b0;
                    end
                end
                ST_FILL: begin
                    r_shadow <= w_shadow_nxt;
                    r_acc    <= r_acc + AW'(w_pc);
                    if (w_fill_last) begin
                        r_dut_x      <= w_shadow_nxt[N-1:0];
                        r_chunk_idx  <= '0;
                        r_settle_cnt <= '0;
                    end else begin
                        r_chunk_idx <= r_chunk_idx + CIW'(1);
                    end
                end
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + STW'(1);
                end
                ST_CHECK: begin
                    if (w_mis) begin
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                        if (!r_first_fail) begin
                            r_fail_vec   <= r_dut_x;
                            r_first_fail <= 1'b1;
                        end
                    end
                    r_vec       <= r_vec + 32'd1;
                    r_acc       <= '0;
                    r_chunk_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign dut_x     = r_dut_x;
    assign busy      = (r_state == ST_FILL) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = (r_state == ST_DONE) && (r_err == 16'd0);
    assign err_count = r_err;
    assign vec_count = r_vec;
    assign fail_vec  = r_fail_vec;
    assign dbg_state = r_state;

endmodule
